// File: rtl/snes_pad_pkg.sv
// Shared constants and types for the multi-port SNES pad emulator.
package snes_pad_pkg;

    localparam int NBTN        = 12;
    localparam int REPORT_BITS = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef logic [NBTN-1:0] snes_btn_t;

endpackage

// File: rtl/snes_pad_if.sv
// Joypad bus between the pad front-ends/SNES core and the port emulator.
interface snes_pad_if #(
    parameter int NPORTS = 2
) ();

    logic                   snes_joy_strb;
    logic [NPORTS-1:0]      snes_joy_clk;
    logic [NPORTS-1:0]      snes_joy_di;
    logic [NPORTS*12-1:0]   buttons;
    logic [NPORTS*12-1:0]   turbo_mask;
    logic [NPORTS-1:0]      connected;
    logic [NPORTS-1:0]      read_done;

    modport master (
        output snes_joy_strb,
        output snes_joy_clk,
        output buttons,
        output turbo_mask,
        output connected,
        input  snes_joy_di,
        input  read_done
    );

    modport slave (
        input  snes_joy_strb,
        input  snes_joy_clk,
        input  buttons,
        input  turbo_mask,
        input  connected,
        output snes_joy_di,
        output read_done
    );

endinterface

// File: rtl/snes_pad_shifter.sv
// One SNES pad port: latch, falling-edge serial shift and read-complete pulse.
module snes_pad_shifter
    import snes_pad_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      strb_i,
    input  logic      joy_clk_i,
    input  logic      connected_i,
    input  snes_btn_t btn_i,
    output logic      di_o,
    output logic      read_done_o
);

    logic [REPORT_BITS-1:0] sr_q, sr_d;
    logic [4:0]             cnt_q, cnt_d;
    logic                   clk_r_q;
    logic                   done_q, done_d;
    logic                   fall;

    assign fall = clk_r_q & ~joy_clk_i;

    // Strobe has priority: a coincident falling edge is swallowed by the load.
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (strb_i) begin
            sr_d  = connected_i ?
                    {{(REPORT_BITS-NBTN){1'b0}}, btn_i} : '0;
            cnt_d = '0;
        end else if (fall) begin
            sr_d   = {connected_i, sr_q[REPORT_BITS-1:1]};
            done_d = (cnt_q == 5'(REPORT_BITS-1));
            if (cnt_q != 5'(REPORT_BITS))
                cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            clk_r_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            clk_r_q <= joy_clk_i;
            done_q  <= done_d;
        end
    end

    assign di_o        = ~sr_q[0];
    assign read_done_o = done_q;

endmodule

// File: rtl/snes_pad_ports.sv
// Multi-port SNES controller emulator with shared turbo divider.
module snes_pad_ports
    import snes_pad_pkg::*;
#(
    parameter int NPORTS   = 2,
    parameter int FREQ     = 21_600_000,
    parameter int TURBO_HZ = 10
) (
    input logic       clk,
    input logic       reset,
    snes_pad_if.slave bus
);

    localparam int TC = FREQ / (2 * TURBO_HZ);
    localparam int DW = (TC > 1) ? $clog2(TC) : 1;

    logic [DW-1:0]     div_q, div_d;
    logic              phase_q, phase_d;
    logic [NPORTS-1:0] di_w;
    logic [NPORTS-1:0] done_w;

    always_comb begin
        div_d   = div_q + 1'b1;
        phase_d = phase_q;
        if (div_q == DW'(TC - 1)) begin
            div_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        snes_btn_t eff;

        // Turbo buttons read pressed only in the high half of the phase.
        assign eff = bus.buttons[NBTN*p +: NBTN]
                   & ~(bus.turbo_mask[NBTN*p +: NBTN]
                       & {NBTN{~phase_q}});

        snes_pad_shifter u_shifter (
            .clk         (clk),
            .reset       (reset),
            .strb_i      (bus.snes_joy_strb),
            .joy_clk_i   (bus.snes_joy_clk[p]),
            .connected_i (bus.connected[p]),
            .btn_i       (eff),
            .di_o        (di_w[p]),
            .read_done_o (done_w[p])
        );
    end

    assign bus.snes_joy_di = di_w;
    assign bus.read_done   = done_w;

endmodule

// File: tb/tb_snes_pad_ports.sv
// Scoreboard bench for snes_pad_ports: four ports, fast turbo divider.
module tb_snes_pad_ports;
    import snes_pad_pkg::*;

    localparam int NP = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    snes_pad_if #(.NPORTS(NP)) bus ();

    snes_pad_ports #(
        .NPORTS   (NP),
        .FREQ     (1000),
        .TURBO_HZ (50)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;
    int ncyc   = 0;

    always @(posedge clk) ncyc <= reset ? 0 : ncyc + 1;

    logic          exp_q [NP][$];
    logic [NP-1:0] prev_jc;
    logic [NP-1:0] exp_di;
    logic [NP-1:0] exp_done;
    int            nsh [NP];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_port(input int p, input logic ph, input logic ld);
        snes_btn_t b, m, e;
        logic c;
        b = bus.buttons[12*p +: 12];
        m = bus.turbo_mask[12*p +: 12];
        c = ld ? bus.connected[p] : 1'b0;
        e = b & ~(m & {12{~ph}});
        exp_q[p].delete();
        for (int k = 0; k < 16; k++)
            exp_q[p].push_back(c ? !(k < 12 && e[k]) : 1'b1);
        exp_q[p].push_back(!bus.connected[p]);
        nsh[p] = 0;
    endtask

    task automatic step(input logic s, input logic [NP-1:0] jc);
        logic ph;
        ph = logic'((ncyc / 10) % 2);
        bus.snes_joy_strb = s;
        bus.snes_joy_clk  = jc;
        for (int p = 0; p < NP; p++) begin
            exp_done[p] = 1'b0;
            if (s) begin
                load_port(p, ph, 1'b1);
            end else if (prev_jc[p] && !jc[p]) begin
                if (exp_q[p].size() > 1)
                    void'(exp_q[p].pop_front());
                if (nsh[p] == 15) exp_done[p] = 1'b1;
                if (nsh[p] < 16) nsh[p]++;
            end
            exp_di[p] = exp_q[p][0];
        end
        prev_jc = jc;
        tick();
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        bus.snes_joy_strb = 1'b0;
        bus.snes_joy_clk  = '0;
        tick();
        reset   = 1'b0;
        prev_jc = '0;
        for (int p = 0; p < NP; p++) begin
            load_port(p, 1'b0, 1'b0);
            exp_di[p]   = 1'b1;
            exp_done[p] = 1'b0;
        end
    endtask

    task automatic test_reset;
        bus.connected  = '1;
        bus.buttons    = '1;
        bus.turbo_mask = '0;
        apply_reset();
        checks++;
        if (bus.snes_joy_di !== 4'hF)
            $display("FAIL reset_di got %b want 1111",
                     bus.snes_joy_di);
        else passed++;
        checks++;
        if (bus.read_done !== 4'h0)
            $display("FAIL reset_done got %b want 0000",
                     bus.read_done);
        else passed++;
    endtask

    task automatic test_basic;
        int d0, d1;
        d0 = 0;
        d1 = 0;
        bus.connected  = 4'b0001;
        bus.buttons    = {12'h0, 12'h0, 12'hFFF, 12'h001};
        bus.turbo_mask = '0;
        for (int i = 0; i < 42; i++) begin
            if (i < 2) step(1'b1, '0);
            else step(1'b0, (i % 2 == 0) ? 4'b0011 : 4'b0000);
            d0 += int'(bus.read_done[0]);
            d1 += int'(bus.read_done[1]);
            checks++;
            if (bus.snes_joy_di !== exp_di ||
                bus.read_done !== exp_done)
                $display("FAIL basic i=%0d di=%b want %b done=%b want %b",
                         i, bus.snes_joy_di, exp_di,
                         bus.read_done, exp_done);
            else passed++;
        end
        checks++;
        if (d0 != 1) $display("FAIL basic_pulses0 got %0d want 1", d0);
        else passed++;
        checks++;
        if (d1 != 1) $display("FAIL basic_pulses1 got %0d want 1", d1);
        else passed++;
    endtask

    task automatic test_turbo;
        bit seen0, seen1;
        seen0 = 0;
        seen1 = 0;
        bus.connected  = 4'b0001;
        bus.buttons    = {36'h0, 12'h002};
        bus.turbo_mask = {36'h0, 12'h002};
        for (int l = 0; l < 8; l++) begin
            for (int c = 0; c < 5; c++) begin
                step(c == 0, (c == 1) ? 4'b0001 : 4'b0000);
                checks++;
                if (bus.snes_joy_di !== exp_di ||
                    bus.read_done !== exp_done)
                    $display("FAIL turbo l=%0d c=%0d di=%b want %b",
                             l, c, bus.snes_joy_di, exp_di);
                else passed++;
                if (c == 2) begin
                    if (bus.snes_joy_di[0]) seen1 = 1;
                    else seen0 = 1;
                end
            end
        end
        checks++;
        if (!(seen0 && seen1))
            $display("FAIL turbo_alt got seen0=%0d seen1=%0d want 1 1",
                     seen0, seen1);
        else passed++;
        bus.turbo_mask = '0;
    endtask

    task automatic test_strobe_clk;
        logic [NP-1:0] jcs [6];
        logic          ss  [6];
        jcs = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0};
        ss  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.connected = 4'b0001;
        bus.buttons   = {36'h0, 12'h001};
        for (int i = 0; i < 6; i++) begin
            step(ss[i], jcs[i]);
            checks++;
            if (bus.snes_joy_di !== exp_di ||
                bus.read_done !== exp_done)
                $display("FAIL strobe_clk i=%0d di=%b want %b",
                         i, bus.snes_joy_di, exp_di);
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        d0 = 0;
        bus.connected = 4'b0001;
        bus.buttons   = {36'h0, 12'h0A5};
        step(1'b1, '0);
        for (int i = 0; i < 14; i++)
            step(1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0000);
        apply_reset();
        checks++;
        if (bus.snes_joy_di !== 4'hF || bus.read_done !== 4'h0)
            $display("FAIL reset_mid di=%b want 1111 done=%b want 0000",
                     bus.snes_joy_di, bus.read_done);
        else passed++;
        for (int i = 0; i < 34; i++) begin
            if (i == 0) step(1'b1, '0);
            else step(1'b0, (i % 2 == 1) ? 4'b0001 : 4'b0000);
            d0 += int'(bus.read_done[0]);
            checks++;
            if (bus.snes_joy_di !== exp_di ||
                bus.read_done !== exp_done)
                $display("FAIL reset_mid_rpt i=%0d di=%b want %b",
                         i, bus.snes_joy_di, exp_di);
            else passed++;
        end
        checks++;
        if (d0 != 1) $display("FAIL reset_mid_pulses got %0d want 1", d0);
        else passed++;
    endtask

    task automatic test_multi;
        int            dn [NP];
        logic [NP-1:0] jc;
        bus.connected = 4'b1111;
        bus.buttons   = {12'h800, 12'h100, 12'h010, 12'h001};
        for (int p = 0; p < NP; p++) dn[p] = 0;
        step(1'b1, '0);
        for (int c = 0; c < 72; c++) begin
            for (int p = 0; p < NP; p++)
                jc[p] = ((c - p + 4) % 4) < 2;
            step(1'b0, jc);
            for (int p = 0; p < NP; p++)
                dn[p] += int'(bus.read_done[p]);
            checks++;
            if (bus.snes_joy_di !== exp_di ||
                bus.read_done !== exp_done)
                $display("FAIL multi c=%0d di=%b want %b done=%b want %b",
                         c, bus.snes_joy_di, exp_di,
                         bus.read_done, exp_done);
            else passed++;
        end
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (dn[p] != 1)
                $display("FAIL multi_pulses p%0d got %0d want 1",
                         p, dn[p]);
            else passed++;
        end
    endtask

    initial begin
        bus.snes_joy_strb = 1'b0;
        bus.snes_joy_clk  = '0;
        bus.connected     = '0;
        bus.buttons       = '0;
        bus.turbo_mask    = '0;
        prev_jc           = '0;
        test_reset();
        test_basic();
        test_turbo();
        test_strobe_clk();
        test_reset_mid();
        test_multi();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
